// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data access controller (optional stall counter: MEM_CTRL_STALL_CNT_EN)
module mem_access_ctrl #(
  parameter int LOAD_EXT    = 1,
  parameter int STALL_CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] paddr,
  input  logic        mapped,
  input  logic        uncached,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_dirty,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  output logic        bus_cached,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        exc_refill,
  output logic [31:0] badvaddr
`ifdef MEM_CTRL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        we_q, uns_q, cached_q, kill_q;

  logic [1:0]  eff_size, eff_size_q;
  logic        misaligned, exc_hit, start;
  logic [4:0]  exc_code_c;
  logic        exc_refill_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, load_data, shifted;

  // Size 3 behaves as a word everywhere except the raw bus_size field
  assign eff_size   = (req_size == 2'd3) ? 2'd2 : req_size;
  assign eff_size_q = (size_q == 2'd3) ? 2'd2 : size_q;
  assign misaligned = ((eff_size == 2'd1) && req_vaddr[0]) ||
                      ((eff_size == 2'd2) && (req_vaddr[1:0] != 2'b00));

  // Prioritised address/TLB exception classification of the incoming request
  always_comb begin
    exc_code_c   = EXC_NONE;
    exc_refill_c = 1'b0;
    if (misaligned) begin
      exc_code_c = req_we ? EXC_ADES : EXC_ADEL;
    end else if (mapped && tlb_miss) begin
      exc_code_c   = req_we ? EXC_TLBS : EXC_TLBL;
      exc_refill_c = 1'b1;
    end else if (mapped && !tlb_valid) begin
      exc_code_c = req_we ? EXC_TLBS : EXC_TLBL;
    end else if (mapped && req_we && !tlb_dirty) begin
      exc_code_c = EXC_MOD;
    end
  end

  assign exc_hit = (exc_code_c != EXC_NONE);
  assign start   = (state_q == S_IDLE) && req_valid && !exc_hit && !flush;

  // Byte-lane strobe and lane-replicated store data for the request
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = req_wdata;
    case (eff_size)
      2'd0: begin
        wstrb_c = 4'b0001 << req_vaddr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_c = req_vaddr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  assign shifted = bus_rdata >> {addr_q[1:0], 3'b000};

  // Align the returned word to the addressed lane and extend it
  always_comb begin
    load_data = shifted;
    if (LOAD_EXT != 0) begin
      case (eff_size_q)
        2'd0:    load_data = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        2'd1:    load_data = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        default: load_data = shifted;
      endcase
    end
  end

  // Next-state logic; a flush after acceptance lets the bus finish but kills the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) state_d = flush ? S_IDLE : S_DONE;
          else             state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: if (bus_data_ok) state_d = (kill_q || flush) ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request latches and load-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      cached_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= (state_d == S_WAIT) && (kill_q || flush);
      if (start) begin
        addr_q   <= paddr;
        wdata_q  <= wdata_c;
        size_q   <= req_size;
        wstrb_q  <= req_we ? wstrb_c : 4'b0000;
        we_q     <= req_we;
        uns_q    <= req_unsigned;
        cached_q <= !uncached;
      end
      if (state_d == S_DONE) rdata_q <= we_q ? 32'b0 : load_data;
    end
  end

  // Output decode
  always_comb begin
    bus_req    = (state_q == S_REQ);
    bus_wr     = we_q;
    bus_size   = size_q;
    bus_addr   = addr_q;
    bus_wstrb  = wstrb_q;
    bus_wdata  = wdata_q;
    bus_cached = cached_q;
    stall      = start || (state_q == S_REQ) || (state_q == S_WAIT);
    resp_valid = (state_q == S_DONE) && !flush;
    rdata      = rdata_q;
    exc_valid  = (state_q == S_IDLE) && req_valid && exc_hit;
    exc_code   = exc_valid ? exc_code_c : EXC_NONE;
    exc_refill = exc_valid && exc_refill_c;
    badvaddr   = exc_valid ? req_vaddr : 32'b0;
  end

`ifdef MEM_CTRL_STALL_CNT_EN
  // Free-running count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_vaddr, req_wdata, paddr;
  logic        mapped, uncached, tlb_miss, tlb_valid, tlb_dirty, flush;
  logic        bus_req, bus_wr, bus_cached, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, rdata, badvaddr;
  logic [3:0]  bus_wstrb;
  logic        stall, resp_valid, exc_valid, exc_refill;
  logic [4:0]  exc_code;
`ifdef MEM_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  longint      stall_total = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_vaddr(req_vaddr), .req_wdata(req_wdata), .paddr(paddr), .mapped(mapped),
    .uncached(uncached), .tlb_miss(tlb_miss), .tlb_valid(tlb_valid), .tlb_dirty(tlb_dirty),
    .flush(flush), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_cached(bus_cached),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_refill(exc_refill), .badvaddr(badvaddr)
`ifdef MEM_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_vaddr = 0; req_wdata = 0;
    paddr = 0; mapped = 0; uncached = 0; tlb_miss = 0; tlb_valid = 1; tlb_dirty = 1;
    flush = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  // One request; alat = REQ cycles before addr_ok, dlat = further cycles to data_ok
  // (0 = same cycle). flush_at is the cycle index after request acceptance, -1 for none.
  task automatic run_txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] vaddr, input logic [31:0] wd, input logic mp,
                         input logic unc, input logic miss, input logic vld, input logic drt,
                         input int alat, input int dlat, input logic [31:0] rd, input int flush_at);
    int nbytes, a, stalls, resps, reqs, estall, eresp, ereqs;
    logic [4:0]  ecode;
    logic        erefill, dropped;
    logic [3:0]  ewstrb;
    logic [31:0] ewdata, erdata, pa, got;
    logic [63:0] v, m;
    nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a       = int'(vaddr[1:0]);
    pa      = vaddr & 32'h1FFF_FFFF;
    ecode   = 0;
    erefill = 0;
    if ((a % nbytes) != 0)   ecode = we ? 5 : 4;
    else if (mp && miss)     begin ecode = we ? 3 : 2; erefill = 1; end
    else if (mp && !vld)     ecode = we ? 3 : 2;
    else if (mp && we && !drt) ecode = 1;
    ewstrb = we ? 4'(((1 << nbytes) - 1) << a) : 4'd0;
    for (int i = 0; i < 4; i++) ewdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    v = {32'b0, rd} >> (8 * a);
    m = (64'd1 << (8 * nbytes)) - 1;
    v = v & m;
    if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (~m);
    erdata = we ? 32'd0 : v[31:0];

    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns; req_vaddr = vaddr;
    req_wdata = wd; paddr = pa; mapped = mp; uncached = unc; tlb_miss = miss;
    tlb_valid = vld; tlb_dirty = drt;
    #1;
    check({tag, " exc_valid"}, exc_valid, ecode != 0);
    if (ecode != 0) begin
      check({tag, " exc_code"}, exc_code, ecode);
      check({tag, " exc_refill"}, exc_refill, erefill);
      check({tag, " badvaddr"}, badvaddr, vaddr);
      check({tag, " exc no bus_req/stall"}, {bus_req, stall}, 2'b00);
      @(posedge clk); #1;
      req_valid = 0;
      return;
    end
    check({tag, " stall on request"}, stall, 1);
    stalls  = 1;
    resps   = 0;
    reqs    = 0;
    got     = 0;
    dropped = 0;
    @(posedge clk); #1;
    req_valid = 0;
    req_vaddr = $urandom;
    paddr     = $urandom;
    req_wdata = $urandom;
    for (int k = 0; k <= alat + dlat + 2; k++) begin
      bus_addr_ok = !dropped && (k == alat);
      bus_data_ok = !dropped && (k == alat + dlat);
      bus_rdata   = (k == alat + dlat) ? rd : $urandom;
      flush       = (k == flush_at);
      #1;
      if (bus_req) reqs++;
      if (stall) stalls++;
      if (resp_valid) begin resps++; got = rdata; end
      if (!dropped && k == alat) begin
        check({tag, " bus_addr"}, bus_addr, pa);
        check({tag, " bus_wr/size/cached"}, {bus_wr, bus_size, bus_cached}, {we, size, ~unc});
        check({tag, " bus_wstrb"}, bus_wstrb, ewstrb);
        if (we) check({tag, " bus_wdata"}, bus_wdata, ewdata);
      end
      if (flush_at == k && k < alat) dropped = 1;
      @(posedge clk); #1;
    end
    bus_addr_ok = 0; bus_data_ok = 0; flush = 0;
    if (flush_at >= 0 && flush_at < alat) begin
      estall = flush_at + 2; eresp = 0; ereqs = flush_at + 1;
    end else begin
      estall = 2 + alat + dlat;
      ereqs  = alat + 1;
      eresp  = (flush_at > alat && flush_at <= alat + dlat + 1) ? 0 : 1;
    end
    stall_total += estall;
    check({tag, " stall cycles"}, stalls, estall);
    check({tag, " bus_req cycles"}, reqs, ereqs);
    check({tag, " resp count"}, resps, eresp);
    if (eresp == 1) check({tag, " rdata"}, got, erdata);
  endtask

  initial begin
    int fsel, al, dl, fa;
    logic [1:0] sz;
    idle_inputs();
    rst_n = 0;
    #12;
    check("reset bus_req/stall/resp/exc", {bus_req, stall, resp_valid, exc_valid}, 4'b0);
    check("reset rdata", rdata, 0);
    check("reset bus_addr/wstrb/wdata", {bus_addr, bus_wstrb, bus_wdata}, 68'd0);
    @(posedge clk); #1;
    rst_n = 1;

    run_txn("lw basic", 0, 2, 0, 32'h8000_0004, 0, 0, 0, 0, 1, 1, 0, 1, 32'h1122_3344, -1);
    run_txn("lb signed", 0, 0, 0, 32'h8000_0003, 0, 0, 0, 0, 1, 1, 0, 1, 32'h80FF_FFFF, -1);
    run_txn("lbu", 0, 0, 1, 32'h8000_0003, 0, 0, 0, 0, 1, 1, 0, 1, 32'h80FF_FFFF, -1);
    run_txn("sh", 1, 1, 0, 32'h8000_0002, 32'h0000_BEEF, 0, 0, 0, 1, 1, 0, 1, 0, -1);
    run_txn("lw misaligned", 0, 2, 0, 32'h0040_0001, 0, 0, 0, 0, 1, 1, 0, 1, 0, -1);
    run_txn("sw tlb miss", 1, 2, 0, 32'h0040_0000, 1, 1, 0, 1, 1, 1, 0, 1, 0, -1);
    run_txn("sw mod", 1, 2, 0, 32'h0040_0000, 1, 1, 0, 0, 1, 0, 0, 1, 0, -1);
    run_txn("flush in wait", 0, 2, 0, 32'h8000_0010, 0, 0, 0, 0, 1, 1, 0, 6, 32'hDEAD_BEEF, 2);
    run_txn("after flush", 0, 2, 0, 32'h8000_0014, 0, 0, 0, 0, 1, 1, 0, 1, 32'hCAFE_F00D, -1);
    run_txn("same-cycle ok", 0, 1, 0, 32'h8000_0016, 0, 0, 0, 0, 1, 1, 0, 0, 32'h8001_0000, -1);

    // Asynchronous reset while a request is outstanding
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_size = 2; req_vaddr = 32'h8000_0020; paddr = 32'h20;
    mapped = 0; tlb_miss = 0; tlb_valid = 1; tlb_dirty = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("async reset abort", {bus_req, stall, resp_valid}, 3'b000);
    check("async reset bus_addr", bus_addr, 0);
    @(posedge clk); #1;
    rst_n = 1;
    stall_total = 0;

    for (int i = 0; i < 4; i++)
      run_txn("uncached lw", 0, 2, 0, 32'hA000_0000 + 32'(4 * i), 0, 0, 1, 0, 1, 1, 2, 2,
              $urandom, -1);
`ifdef MEM_CTRL_STALL_CNT_EN
    check("stall_cnt 4x6", stall_cnt, 24);
`endif

    for (int i = 0; i < 80; i++) begin
      sz   = 2'($urandom_range(0, 3));
      al   = $urandom_range(0, 3);
      dl   = $urandom_range(0, 4);
      fsel = $urandom_range(0, 9);
      fa   = -1;
      if (fsel == 0 && al > 0)      fa = $urandom_range(0, al - 1);
      else if (fsel == 1 && dl > 0) fa = al + $urandom_range(1, dl);
      else if (fsel == 2)           fa = al + dl + 1;
      run_txn("random", 1'($urandom), sz, 1'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
              al, dl, $urandom, fa);
    end
`ifdef MEM_CTRL_STALL_CNT_EN
    check("stall_cnt total", stall_cnt, stall_total[31:0]);
`endif
    check("final idle", {bus_req, stall, resp_valid}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
